// File: rtl/gfx_line_sched_if.sv
// Signal bundle between gfx_line_sched and its neighbours: video timing, the
// CPU register bus and the fetch/render engine.
interface gfx_line_sched_if;
    logic        line_start;
    logic [8:0]  vid_vcnt;
    logic        gfx_idle;
    logic        reg_wr;
    logic [2:0]  reg_addr;
    logic [15:0] reg_wrdata;
    logic [15:0] reg_rddata;
    logic [1:0]  gfx_mode;
    logic        sprites_enable;
    logic [8:0]  scrx;
    logic [7:0]  scry;
    logic [7:0]  vline;
    logic        start;
    logic        irq;

    // Environment side: timing generator, CPU and fetch engine.
    modport master (
        output line_start, vid_vcnt, gfx_idle, reg_wr, reg_addr, reg_wrdata,
        input  reg_rddata, gfx_mode, sprites_enable, scrx, scry, vline, start, irq
    );

    // The scheduler itself.
    modport slave (
        input  line_start, vid_vcnt, gfx_idle, reg_wr, reg_addr, reg_wrdata,
        output reg_rddata, gfx_mode, sprites_enable, scrx, scry, vline, start, irq
    );
endinterface

// File: rtl/gfx_line_sched.sv
// Per-scanline sequencer: CPU shadow registers, per-line latching of render
// parameters, start/overrun tracking and line-compare / vblank interrupts.
module gfx_line_sched #(
    parameter logic [7:0] FIRST_LINE = 8'd15,
    parameter logic [7:0] LAST_LINE  = 8'd214
) (
    input  logic             clk,
    input  logic             reset,
    gfx_line_sched_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        RENDER = 1'b1
    } state_e;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_SCRX    = 3'd1;
    localparam logic [2:0] A_SCRY    = 3'd2;
    localparam logic [2:0] A_LINECMP = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;
    localparam logic [2:0] A_VLINE   = 3'd5;

    state_e      state_q, state_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [8:0]  scrx_sh_q, scrx_sh_d;
    logic [7:0]  scry_sh_q, scry_sh_d;
    logic [7:0]  linecmp_q, linecmp_d;
    logic        pend_line_q, pend_line_d;
    logic        pend_vbl_q, pend_vbl_d;
    logic        overrun_q, overrun_d;
    logic [1:0]  mode_q, mode_d;
    logic        spr_q, spr_d;
    logic [8:0]  scrx_q, scrx_d;
    logic [7:0]  scry_q, scry_d;
    logic [7:0]  vline_q, vline_d;
    logic        start_q, start_d;

    logic [7:0]  tgt;
    logic        line_active;
    logic        line_hit;
    logic        vbl_hit;
    logic [2:0]  w1c;
    logic [15:0] rddata;
    logic        unused_wrdata;

    assign tgt         = bus.vid_vcnt[7:0] + 8'd1;
    assign line_active = !bus.vid_vcnt[8] && (tgt >= FIRST_LINE) && (tgt <= LAST_LINE);
    assign line_hit    = !bus.vid_vcnt[8] && (bus.vid_vcnt[7:0] == linecmp_q);
    assign vbl_hit     = (bus.vid_vcnt == ({1'b0, LAST_LINE} + 9'd1));
    assign w1c         = (bus.reg_wr && bus.reg_addr == A_STATUS) ? bus.reg_wrdata[2:0] : 3'b000;
    assign unused_wrdata = ^bus.reg_wrdata[15:9];

    // NOTE: every _d gets its hold value first so no path through this block
    // can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        scrx_sh_d   = scrx_sh_q;
        scry_sh_d   = scry_sh_q;
        linecmp_d   = linecmp_q;
        mode_d      = mode_q;
        spr_d       = spr_q;
        scrx_d      = scrx_q;
        scry_d      = scry_q;
        vline_d     = vline_q;
        start_d     = 1'b0;
        overrun_d   = overrun_q;

        if (bus.reg_wr) begin
            case (bus.reg_addr)
                A_CTRL:    ctrl_d    = bus.reg_wrdata[4:0];
                A_SCRX:    scrx_sh_d = bus.reg_wrdata[8:0];
                A_SCRY:    scry_sh_d = bus.reg_wrdata[7:0];
                A_LINECMP: linecmp_d = bus.reg_wrdata[7:0];
                default:   ;
            endcase
        end

        // A set in the same cycle as its W1C wins because it is ORed in last.
        pend_line_d = (pend_line_q & ~w1c[0]) | (bus.line_start & line_hit);
        pend_vbl_d  = (pend_vbl_q  & ~w1c[1]) | (bus.line_start & vbl_hit);
        overrun_d   = overrun_q & ~w1c[2];

        case (state_q)
            IDLE: begin
                if (bus.line_start && line_active) begin
                    state_d = RENDER;
                end
            end
            RENDER: begin
                if (bus.line_start) begin
                    state_d = line_active ? RENDER : IDLE;
                    if (!bus.gfx_idle) begin
                        overrun_d = 1'b1;
                    end
                end else if (bus.gfx_idle && !start_q) begin
                    // The idle level during the start cycle may be left over
                    // from the previous line, so it is not trusted.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Latch from the registered shadows, so a same-cycle CPU write only
        // reaches the following line.
        if (bus.line_start && line_active) begin
            mode_d  = ctrl_q[1:0];
            spr_d   = ctrl_q[2];
            scrx_d  = scrx_sh_q;
            scry_d  = scry_sh_q;
            vline_d = tgt;
            start_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            scrx_sh_q   <= '0;
            scry_sh_q   <= '0;
            linecmp_q   <= '0;
            pend_line_q <= 1'b0;
            pend_vbl_q  <= 1'b0;
            overrun_q   <= 1'b0;
            mode_q      <= '0;
            spr_q       <= 1'b0;
            scrx_q      <= '0;
            scry_q      <= '0;
            vline_q     <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            scrx_sh_q   <= scrx_sh_d;
            scry_sh_q   <= scry_sh_d;
            linecmp_q   <= linecmp_d;
            pend_line_q <= pend_line_d;
            pend_vbl_q  <= pend_vbl_d;
            overrun_q   <= overrun_d;
            mode_q      <= mode_d;
            spr_q       <= spr_d;
            scrx_q      <= scrx_d;
            scry_q      <= scry_d;
            vline_q     <= vline_d;
            start_q     <= start_d;
        end
    end

    always_comb begin
        rddata = 16'h0000;
        case (bus.reg_addr)
            A_CTRL:    rddata = {11'b0, ctrl_q};
            A_SCRX:    rddata = {7'b0, scrx_sh_q};
            A_SCRY:    rddata = {8'b0, scry_sh_q};
            A_LINECMP: rddata = {8'b0, linecmp_q};
            A_STATUS:  rddata = {13'b0, overrun_q, pend_vbl_q, pend_line_q};
            A_VLINE:   rddata = {8'b0, vline_q};
            default:   rddata = 16'h0000;
        endcase
    end

    assign bus.reg_rddata     = rddata;
    assign bus.gfx_mode       = mode_q;
    assign bus.sprites_enable = spr_q;
    assign bus.scrx           = scrx_q;
    assign bus.scry           = scry_q;
    assign bus.vline          = vline_q;
    assign bus.start          = start_q;
    assign bus.irq            = (pend_line_q & ctrl_q[3]) | (pend_vbl_q & ctrl_q[4]);

endmodule

// File: tb/tb_gfx_line_sched.sv
// Directed bench for gfx_line_sched: expected line latches are queued when a
// line_start is driven and compared whenever the DUT pulses start.
module tb_gfx_line_sched;

    typedef struct packed {
        logic [7:0] vline;
        logic [1:0] mode;
        logic       spr;
        logic [8:0] scrx;
        logic [7:0] scry;
    } line_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gfx_line_sched_if bus();

    gfx_line_sched #(.FIRST_LINE(8'd15), .LAST_LINE(8'd214)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    line_t      sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [4:0] m_ctrl;
    logic [8:0] m_scrx;
    logic [7:0] m_scry;
    line_t      m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic line_t outs();
        return {bus.vline, bus.gfx_mode, bus.sprites_enable, bus.scrx, bus.scry};
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        m_scrx = '0;
        m_scry = '0;
        m_out  = '0;
    endtask

    // One clock of stimulus; the model latches pre-write shadows like hardware.
    task automatic cycle(input bit ls, input logic [8:0] vcnt, input bit wr,
                         input logic [2:0] addr, input logic [15:0] data);
        logic [7:0] tgt;
        bus.line_start = ls;
        bus.vid_vcnt   = vcnt;
        bus.reg_wr     = wr;
        bus.reg_addr   = addr;
        bus.reg_wrdata = data;
        if (ls && !reset) begin
            tgt = vcnt[7:0] + 8'd1;
            if (!vcnt[8] && tgt >= 8'd15 && tgt <= 8'd214) begin
                m_out = {tgt, m_ctrl[1:0], m_ctrl[2], m_scrx, m_scry};
                sb.push_back(m_out);
            end
        end
        if (wr && !reset) begin
            case (addr)
                3'd0: m_ctrl = data[4:0];
                3'd1: m_scrx = data[8:0];
                3'd2: m_scry = data[7:0];
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        bus.line_start = 1'b0;
        bus.reg_wr     = 1'b0;
        @(negedge clk);
        #1;
        check("start_issued", sb.size(), 0);
    endtask

    task automatic idle();
        cycle(1'b0, 9'd0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        bus.reg_addr = a;
        #1;
        check(tag, bus.reg_rddata, exp);
    endtask

    always @(negedge clk) begin
        line_t e;
        if (bus.start === 1'b1) begin
            if (sb.size() == 0) begin
                check("start_unexpected", bus.start, 1'b0);
            end else begin
                e = sb.pop_front();
                check("start_outputs", outs(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.line_start = 1'b0;
        bus.vid_vcnt   = '0;
        bus.gfx_idle   = 1'b1;
        bus.reg_wr     = 1'b0;
        bus.reg_addr   = '0;
        bus.reg_wrdata = '0;
        model_reset();

        // Reset: a coincident line_start and register write are ignored.
        cycle(1'b1, 9'd14, 1'b1, 3'd0, 16'h001F);
        idle();
        check("rst_outputs", outs(), '0);
        check("rst_irq", bus.irq, 1'b0);
        rd(3'd0, 16'h0000, "rst_ctrl");
        rd(3'd4, 16'h0000, "rst_status");
        reset = 1'b0;

        // Shadow writes with reserved bits set; reserved bits read back 0.
        cycle(1'b0, 9'd0, 1'b1, 3'd0, 16'hFFE5);
        cycle(1'b0, 9'd0, 1'b1, 3'd1, 16'hFFA3);
        rd(3'd0, 16'h0005, "ctrl_rd");
        rd(3'd1, 16'h01A3, "scrx_rd");

        // First active line and the last active line.
        cycle(1'b1, 9'd14, 1'b0, 3'd0, 16'h0);
        rd(3'd5, 16'h000F, "vline_rd_15");
        idle();
        cycle(1'b1, 9'd213, 1'b0, 3'd0, 16'h0);
        idle();

        // Inactive lines: outputs hold, no start.
        cycle(1'b1, 9'd214, 1'b0, 3'd0, 16'h0);
        check("hold_214", outs(), m_out);
        cycle(1'b1, 9'd300, 1'b0, 3'd0, 16'h0);
        check("hold_300", outs(), m_out);
        cycle(1'b1, 9'd13, 1'b0, 3'd0, 16'h0);
        check("hold_13", outs(), m_out);
        rd(3'd4, 16'h0000, "status_clean");

        // Reserved addresses.
        cycle(1'b0, 9'd0, 1'b1, 3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, "rsv6_rd");
        rd(3'd0, 16'h0005, "ctrl_after_rsv");

        // SCRY written in the same cycle as line_start applies one line later.
        cycle(1'b1, 9'd50, 1'b1, 3'd2, 16'h0040);
        idle();
        cycle(1'b1, 9'd51, 1'b0, 3'd0, 16'h0);
        rd(3'd2, 16'h0040, "scry_rd");
        idle();

        // Overrun: two active lines with gfx_idle held low.
        bus.gfx_idle = 1'b0;
        cycle(1'b1, 9'd60, 1'b0, 3'd0, 16'h0);
        idle();
        cycle(1'b1, 9'd61, 1'b0, 3'd0, 16'h0);
        rd(3'd4, 16'h0004, "overrun_set");
        bus.gfx_idle = 1'b1;
        idle();
        cycle(1'b0, 9'd0, 1'b1, 3'd4, 16'h0004);
        rd(3'd4, 16'h0000, "overrun_clr");

        // Line-compare interrupt, enabled.
        cycle(1'b0, 9'd0, 1'b1, 3'd3, 16'd100);
        cycle(1'b0, 9'd0, 1'b1, 3'd0, 16'h000D);
        cycle(1'b1, 9'd100, 1'b0, 3'd0, 16'h0);
        check("irq_line_en", bus.irq, 1'b1);
        rd(3'd4, 16'h0001, "pend_line_set");
        cycle(1'b0, 9'd0, 1'b1, 3'd4, 16'h0001);
        check("irq_line_clr", bus.irq, 1'b0);
        rd(3'd4, 16'h0000, "pend_line_clr");

        // Line-compare with enable off: pending sets, irq stays low.
        cycle(1'b0, 9'd0, 1'b1, 3'd0, 16'h0005);
        cycle(1'b1, 9'd100, 1'b0, 3'd0, 16'h0);
        check("irq_line_dis", bus.irq, 1'b0);
        rd(3'd4, 16'h0001, "pend_line_dis");
        cycle(1'b0, 9'd0, 1'b1, 3'd0, 16'h000D);
        check("irq_late_en", bus.irq, 1'b1);
        cycle(1'b0, 9'd0, 1'b1, 3'd4, 16'h0001);
        check("irq_late_clr", bus.irq, 1'b0);

        // Vblank set coincident with its W1C: set wins.
        cycle(1'b0, 9'd0, 1'b1, 3'd0, 16'h0015);
        cycle(1'b1, 9'd215, 1'b1, 3'd4, 16'h0002);
        rd(3'd4, 16'h0002, "vbl_set_wins");
        check("irq_vbl", bus.irq, 1'b1);
        check("hold_215", outs(), m_out);

        // Reset while rendering, then the next line starts cleanly from IDLE.
        bus.gfx_idle = 1'b0;
        cycle(1'b1, 9'd20, 1'b0, 3'd0, 16'h0);
        reset = 1'b1;
        model_reset();
        idle();
        check("rst_render_outputs", outs(), '0);
        check("rst_render_irq", bus.irq, 1'b0);
        rd(3'd4, 16'h0000, "rst_render_status");
        reset = 1'b0;
        cycle(1'b1, 9'd30, 1'b0, 3'd0, 16'h0);
        rd(3'd4, 16'h0000, "no_overrun_after_rst");
        bus.gfx_idle = 1'b1;
        idle();

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gfx_line_sched.md
# gfx_line_sched

Per-scanline sequencer and register front-end for the tile/bitmap/sprite line renderer. It holds the CPU-visible graphics control registers and latches a consistent copy of mode, sprite enable and scroll values at every line start, so raster splits take effect cleanly on the next line. It issues one `start` pulse and line number per active line to the fetch engine, tracks render completion, flags overruns and raises line-compare and vblank interrupts. It sits between the video timing generator, the CPU I/O bus and the graphics fetch/render engine.

## Interface
- `FIRST_LINE`, 15: first render line number, 8 bits.
- `LAST_LINE`, 214: last render line number, 8 bits (200 active lines).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse from video timing at the start of each scanline.
- `vid_vcnt`  in  9  current scanline count from video timing; valid while `line_start` is high.
- `gfx_idle`  in  1  high when the fetch engine has finished the current line's work.
- `reg_wr`  in  1  CPU register write strobe.
- `reg_addr`  in  3  register select.
- `reg_wrdata`  in  16  write data.
- `reg_rddata`  out  16  combinational read data for `reg_addr`.
- `gfx_mode`  out  2  latched mode: 00 disabled, 01 tile, 11 4bpp bitmap.
- `sprites_enable`  out  1  latched sprite enable.
- `scrx`  out  9  latched X scroll.
- `scry`  out  8  latched Y scroll.
- `vline`  out  8  line number to render.
- `start`  out  1  one-cycle render start pulse.
- `irq`  out  1  OR of enabled pending interrupts.

## Operation
- Register map (shadow registers, CPU-written):
  - 0 CTRL: [1:0] mode, [2] sprites_enable, [3] line-IRQ enable, [4] vblank-IRQ enable.
  - 1 SCRX: [8:0].
  - 2 SCRY: [7:0].
  - 3 LINECMP: [7:0].
  - 4 STATUS: [0] line IRQ pending, [1] vblank pending, [2] overrun (sticky). Write-1-to-clear.
  - 5 VLINE: read-only, {8'b0, vline}.
  - 6, 7: read 0; writes ignored.
- Unused bits read 0. Writes to reserved bits are dropped.
- Target line `tgt = vid_vcnt[7:0] + 1` (8-bit wrap). A line is active when `vid_vcnt[8]==0` and `FIRST_LINE <= tgt <= LAST_LINE`.
- FSM states:
  - IDLE: after reset and between lines.
  - RENDER: `start` has been issued and `gfx_idle` has not yet been seen high.
- IDLE + `line_start` + active:
  - Copy shadow mode, sprites_enable, scrx and scry to the outputs.
  - Set `vline = tgt` and pulse `start`.
  - Go to RENDER.
- IDLE + `line_start` + inactive: outputs stay unchanged and no `start` is issued.
- RENDER + `gfx_idle` (sampled the cycle after `start` or later): go to IDLE.
- RENDER + `line_start`:
  - If `gfx_idle` is low, set overrun.
  - Treat the line exactly as the IDLE case: latch, pulse `start` if active (otherwise go to IDLE).
- Line IRQ: pending is set at `line_start` when `vid_vcnt[8]==0` and `vid_vcnt[7:0] == LINECMP`.
- Vblank IRQ: pending is set at `line_start` when `vid_vcnt == LAST_LINE+1`.
- `irq = (pend_line & en_line) | (pend_vbl & en_vbl)`.
- Pending bits set regardless of their enable bit.
- Simultaneous set and W1C of the same bit in one cycle: set wins.
- A shadow write in the same cycle as `line_start`: the latched value is the pre-write shadow value. The new value applies from the next line.

## Timing
- All state is registered. `start` and the latched outputs change in the cycle after `line_start` is sampled high, so the latency is 1.
- `start` is exactly one cycle wide, and at most one `start` is issued per `line_start`.
- Register writes take effect on the shadow at the next clock edge. `reg_rddata` reflects them in the following cycle.
- Reset values:
  - All shadows and latched outputs 0.
  - `vline=0`, `start=0`, state IDLE.
  - All pending/overrun bits 0, `irq=0`.
- Reset asserted mid-RENDER returns to IDLE immediately. A `line_start` coincident with reset is ignored.
- `gfx_idle` is ignored in IDLE. It is not required to drop after `start`: any high sample in RENDER from the cycle after `start` onward completes the line.

## Test plan
- Write CTRL=0x0005 and SCRX=0x1A3, then pulse `line_start` with vcnt=14 -> one cycle later `start`=1, `vline`=15, `gfx_mode`=01, `sprites_enable`=1, `scrx`=0x1A3.
- `line_start` with vcnt=214 and with vcnt=300 -> no `start`; outputs hold previous values.
- Write SCRY=0x40 in the same cycle as `line_start` (vcnt=50) -> `scry` keeps its old value for `vline`=51 and becomes 0x40 for `vline`=52.
- Hold `gfx_idle`=0 across two consecutive active `line_start`s -> STATUS[2]=1 and the second `start` is still issued. Write STATUS=0x4 -> bit clears.
- LINECMP=100 with line-IRQ enabled, `line_start` at vcnt=100 -> `irq`=1 next cycle. W1C STATUS=0x1 -> `irq`=0. Repeat with enable=0 -> pending sets, `irq` stays 0.
- Vblank `line_start` (vcnt=215) coincident with W1C of STATUS[1] -> bit remains 1. Assert reset while in RENDER -> all outputs return to their reset values.
